// File: rtl/seq_checker_if.sv
// Sample stream into the sequence checker and its status outputs.
// The master drives samples and clear; the slave is the checker.
interface seq_checker_if #(
  parameter int unsigned ERR_W = 8,
  parameter int unsigned PER_W = 8
) ();
  logic             in_vld;
  logic [2:0]       in_data;
  logic             clr;
  logic             locked;
  logic             mismatch;
  logic [2:0]       exp_data;
  logic [ERR_W-1:0] err_cnt;
  logic [PER_W-1:0] period_cnt;

  modport master (
    output in_vld, in_data, clr,
    input  locked, mismatch, exp_data, err_cnt, period_cnt
  );

  modport slave (
    input  in_vld, in_data, clr,
    output locked, mismatch, exp_data, err_cnt, period_cnt
  );
endinterface

// File: rtl/seq_checker.sv
// Locks onto a programmed cyclic 3-bit sequence and then reports mismatches,
// a saturating error count and a count of completed periods.
module seq_checker #(
  parameter int unsigned LEN      = 8,
  parameter logic [23:0] SEQ      = 24'h97E4C8,
  parameter int unsigned LOCK_THR = 8,
  parameter int unsigned LOSS_THR = 2,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned PER_W    = 8
) (
  input logic           clk,
  input logic           rst,
  seq_checker_if.slave  bus
);

  localparam logic [2:0] LastIdx = 3'(LEN - 1);
  localparam logic [2:0] IdxOne  = 3'(1 % LEN);
  localparam logic [7:0] LockThr = 8'(LOCK_THR);
  localparam logic [3:0] LossThr = 4'(LOSS_THR);

  typedef enum logic [1:0] {StHunt, StSync, StLock} state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       run_q, run_d;
  logic [3:0]       miss_q, miss_d;
  logic             mismatch_q, mismatch_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [PER_W-1:0] per_q, per_d;

  function automatic logic [2:0] seq_at(input logic [2:0] i);
    return SEQ[3*i +: 3];
  endfunction

  logic       hit, hit0;
  logic [2:0] idx_inc;

  assign hit     = (bus.in_data == seq_at(idx_q));
  assign hit0    = (bus.in_data == seq_at(3'd0));
  assign idx_inc = (idx_q == LastIdx) ? 3'd0 : idx_q + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHunt;
      idx_q      <= '0;
      run_q      <= '0;
      miss_q     <= '0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      per_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      run_q      <= run_d;
      miss_q     <= miss_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      per_q      <= per_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    run_d      = run_q;
    miss_d     = miss_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    per_d      = per_q;
    if (bus.in_vld) begin
      unique case (state_q)
        StHunt: begin
          if (hit0) begin
            idx_d   = IdxOne;
            run_d   = 8'd1;
            miss_d  = '0;
            state_d = (LockThr == 8'd1) ? StLock : StSync;
          end
        end
        StSync: begin
          if (hit) begin
            idx_d = idx_inc;
            run_d = run_q + 8'd1;
            if (run_q + 8'd1 == LockThr) begin
              state_d = StLock;
              miss_d  = '0;
            end
          end else if (hit0) begin
            // The breaking sample may itself be a fresh start of the cycle.
            idx_d = IdxOne;
            run_d = 8'd1;
          end else begin
            state_d = StHunt;
            idx_d   = '0;
            run_d   = '0;
          end
        end
        StLock: begin
          // Position advances regardless of match so a lone bad sample
          // does not shift alignment.
          idx_d = idx_inc;
          if (idx_q == LastIdx) per_d = per_q + PER_W'(1);
          if (hit) begin
            miss_d = '0;
          end else begin
            mismatch_d = 1'b1;
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (miss_q + 4'd1 == LossThr) begin
              state_d = StHunt;
              idx_d   = '0;
              run_d   = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
    if (bus.clr) begin
      err_d = '0;
      per_d = '0;
    end
  end

  always_comb begin
    bus.locked     = (state_q == StLock);
    bus.mismatch   = mismatch_q;
    bus.exp_data   = (state_q == StHunt) ? 3'd0 : seq_at(idx_q);
    bus.err_cnt    = err_q;
    bus.period_cnt = per_q;
  end

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker: the driver queues hand-computed expected
// outputs per issued cycle and a monitor checks them after each edge.
module tb_seq_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_checker_if #(.ERR_W(8), .PER_W(8)) bus ();

  seq_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       lck;
    logic       mm;
    logic [2:0] exp;
    logic [7:0] err;
    logic [7:0] per;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;
  logic [2:0] g [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  task automatic chk(input string name, input int id, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, id, act, req);
    end
  endtask

  task automatic check_all(input exp_t e);
    chk("locked", e.id, int'(bus.locked), int'(e.lck));
    chk("mismatch", e.id, int'(bus.mismatch), int'(e.mm));
    chk("exp_data", e.id, int'(bus.exp_data), int'(e.exp));
    chk("err_cnt", e.id, int'(bus.err_cnt), int'(e.err));
    chk("period_cnt", e.id, int'(bus.period_cnt), int'(e.per));
  endtask

  // Drive one cycle and queue the outputs expected right after its edge.
  task automatic step(input logic vld, input logic [2:0] d, input logic c,
                      input logic lck, input logic mm, input logic [2:0] ex,
                      input int err, input int per);
    exp_t e;
    @(negedge clk);
    bus.in_vld  = vld;
    bus.in_data = d;
    bus.clr     = c;
    step_id++;
    e.id  = step_id;
    e.lck = lck;
    e.mm  = mm;
    e.exp = ex;
    e.err = 8'(err);
    e.per = 8'(per);
    q.push_back(e);
    @(posedge clk);
    #2;
    bus.in_vld = 1'b0;
    bus.clr    = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        #1;
        e = q.pop_front();
        check_all(e);
      end
    end
  end

  initial begin
    exp_t z;
    bus.in_vld  = 1'b0;
    bus.in_data = 3'd0;
    bus.clr     = 1'b0;
    z = '{id: 0, lck: 1'b0, mm: 1'b0, exp: 3'd0, err: 8'd0, per: 8'd0};
    repeat (2) @(posedge clk);
    #1;
    check_all(z);
    @(negedge clk);
    rst = 1'b0;

    // Acquire lock on the first full period.
    for (int i = 0; i < 8; i++)
      step(1'b1, g[i], 1'b0, i == 7, 1'b0, g[(i + 1) % 8], 0, 0);
    // Clean period in LOCK.
    for (int i = 0; i < 8; i++)
      step(1'b1, g[i], 1'b0, 1'b1, 1'b0, g[(i + 1) % 8], 0, (i == 7) ? 1 : 0);
    // Single corrupted sample, then an idle cycle clears the pulse.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 2) ? 3'd7 : g[i], 1'b0, 1'b1, i == 2, g[(i + 1) % 8],
           (i >= 2) ? 1 : 0, (i == 7) ? 2 : 1);
      if (i == 2) step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, g[3], 1, 1);
    end
    // Two consecutive misses drop lock; a following 0 enters SYNC.
    step(1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 3'd1, 2, 2);
    step(1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 3'd0, 3, 2);
    step(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 3, 2);
    // SYNC broken by a 4, then HUNT ignores 4s and gaps until a 0.
    step(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0, 3, 2);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3, 2);
    step(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0, 3, 2);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3, 2);
    step(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 3, 2);
    // Relock; the wrap that completes SYNC is not a counted period.
    for (int i = 1; i < 8; i++)
      step(1'b1, g[i], 1'b0, i == 7, 1'b0, g[(i + 1) % 8], 3, 2);
    step(1'b1, g[0], 1'b0, 1'b1, 1'b0, g[1], 3, 2);

    // Asynchronous reset mid-LOCK with err_cnt=3.
    @(negedge clk);
    #1;
    chk("err_before_rst", 0, int'(bus.err_cnt), 3);
    rst = 1'b1;
    #1;
    check_all(z);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Relock, then clear coinciding with a mismatch and with a period wrap.
    for (int i = 0; i < 8; i++)
      step(1'b1, g[i], 1'b0, i == 7, 1'b0, g[(i + 1) % 8], 0, 0);
    step(1'b1, 3'd7, 1'b1, 1'b1, 1'b1, g[1], 0, 0);
    for (int i = 1; i < 8; i++)
      step(1'b1, g[i], (i == 7), 1'b1, 1'b0, g[(i + 1) % 8], 0, 0);
    for (int i = 0; i < 8; i++)
      step(1'b1, g[i], 1'b0, 1'b1, 1'b0, g[(i + 1) % 8], 0, (i == 7) ? 1 : 0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Downstream consumer of the 3-bit sequence generator output.
- Samples the generator's 3-bit stream and locks onto a programmed cyclic sequence.
- Once locked, flags mismatches and counts errors and completed periods.
- Serves as the self-checking stage for the sequence generator in system benches and on-chip debug.

Parameters:
- LEN, 8: number of entries in the cyclic sequence (2..8).
- SEQ, 24'h97E4C8: packed expected sequence. Entry i occupies bits [3i+2:3i]. Default is the 3-bit Gray cycle 0,1,3,2,6,7,5,4.
- LOCK_THR, 8: consecutive matches needed to enter LOCK (1..255).
- LOSS_THR, 2: consecutive mismatches in LOCK that drop lock (1..15).
- ERR_W, 8: width of err_cnt.
- PER_W, 8: width of period_cnt.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_vld  input  1  in_data is valid this cycle.
- in_data  input  3  sample from the sequence generator.
- clr  input  1  synchronous clear of err_cnt and period_cnt.
- locked  output  1  high while in LOCK.
- mismatch  output  1  one-cycle pulse: the LOCK sample just taken mismatched.
- exp_data  output  3  value expected on the next valid sample; 0 in HUNT.
- err_cnt  output  ERR_W  saturating mismatch count.
- period_cnt  output  PER_W  completed periods in LOCK; wraps.

Behaviour:
- All outputs are registered. Reset (async, rst=1) forces:
  - state=HUNT, idx=0, run=0, miss=0;
  - locked=0, mismatch=0, exp_data=0, err_cnt=0, period_cnt=0.
- Reset may assert at any time, including mid-LOCK. Deassertion takes effect at the next clk edge.
- Nothing advances when in_vld=0, except clr. mismatch is 0 in any cycle following in_vld=0.
- Latency: a sample taken at edge k is reflected on all outputs immediately after edge k.
- State machine (idx = expected position, 0..LEN-1):
  - HUNT:
    - in_vld & in_data==SEQ[0] -> SYNC, idx=1 (mod LEN), run=1.
    - If LOCK_THR==1 -> LOCK directly.
    - Otherwise stay in HUNT.
  - SYNC:
    - Match (in_data==SEQ[idx]) -> idx=(idx+1) mod LEN, run++. When run reaches LOCK_THR -> LOCK, miss=0.
    - Mismatch -> re-evaluate the same sample as HUNT would: if it equals SEQ[0], go to SYNC with idx=1, run=1; else go to HUNT.
    - Mismatches in SYNC never touch err_cnt or mismatch.
  - LOCK:
    - Every valid sample advances idx=(idx+1) mod LEN, whether it matches or not. This tolerates single corrupted samples.
    - Match -> miss=0.
    - Mismatch -> mismatch=1 for one cycle, err_cnt+1 (saturates at all-ones), miss++.
    - When miss reaches LOSS_THR -> HUNT, idx=0, run=0, locked=0 on the same edge.
    - When idx wraps LEN-1 -> 0 in LOCK, period_cnt+1 (modular), whether the final sample matched or not.
    - The wrap that completes entry into LOCK, while still in SYNC, is not counted.
- exp_data = SEQ[idx] in SYNC and LOCK; 0 in HUNT.
- clr=1 zeroes err_cnt and period_cnt on that edge. clr takes priority over a same-cycle increment. clr does not affect state, idx, locked, or mismatch.

Test Plan:
- Default params; after reset feed valid 0,1,3,2,6,7,5,4 -> locked=1 after 8th sample; exp_data=0; err_cnt=0; period_cnt=0.
- Continue feeding 0,1,3,2,6,7,5,4 -> period_cnt=1 after the 4; mismatch never pulses.
- In LOCK, feed 0,1,7,2,6,7,5,4 -> mismatch pulses once after the 7; err_cnt=1; locked stays 1; period_cnt increments on the 4.
- In LOCK, feed two wrong samples in a row (5,5 where 0,1 expected) -> err_cnt +2; locked=0 after the second; exp_data=0. Next 0 enters SYNC with exp_data=1.
- Hunt/gaps: feed 4,4,0 with in_vld toggling low between samples -> HUNT ignores 4s and invalid cycles; SYNC entered on 0; exp_data=1.
- Assert rst mid-LOCK with err_cnt=3 -> all outputs 0 immediately, without a clock edge.
- Assert clr on the same cycle as a mismatch -> err_cnt=0 afterwards and mismatch still pulses.
